// File: rtl/timer_key_ctrl.sv
// Front-panel controller for the countdown timer: debounce-strobe prescaler,
// key arbitration, set/run/pause/done state machine and setpoint registers.
module timer_key_ctrl #(
  parameter int DEB_PRESC_BITS   = 10,
  parameter int DEB_PRESC_MODULO = 1000,
  parameter int MAX_MIN          = 59
) (
  input  logic       CLK,
  input  logic       CLR_N,
  input  logic       CE,
  input  logic       KEY_MODE,
  input  logic       KEY_INC,
  input  logic       KEY_DEC,
  input  logic       KEY_START,
  input  logic       TIMER_ZERO,
  output logic       DEB_CE,
  output logic       DEB_REP_EN,
  output logic [5:0] SET_MIN,
  output logic [5:0] SET_SEC,
  output logic       LOAD,
  output logic       RUN,
  output logic       ALARM,
  output logic [2:0] STATE
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SET_MIN = 3'd1,
    ST_SET_SEC = 3'd2,
    ST_RUN     = 3'd3,
    ST_PAUSE   = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  localparam logic [DEB_PRESC_BITS-1:0] PRESC_LAST = DEB_PRESC_BITS'(DEB_PRESC_MODULO - 1);
  localparam logic [5:0] MIN_LAST = 6'(MAX_MIN);
  localparam logic [5:0] SEC_LAST = 6'd59;

  logic [DEB_PRESC_BITS-1:0] presc_r;
  logic                      deb_ce_r;
  state_t                    state_r, state_s;
  logic [5:0]                set_min_r, set_min_s;
  logic [5:0]                set_sec_r, set_sec_s;
  logic                      load_r, load_s;
  logic                      run_r, alarm_r, rep_en_r;
  logic                      nonzero_s, any_key_s;

  assign nonzero_s = (set_min_r != 6'd0) || (set_sec_r != 6'd0);
  assign any_key_s = KEY_START | KEY_MODE | KEY_INC | KEY_DEC;

  // Debounce-strobe prescaler: counts CE ticks, strobes once per wrap.
  always_ff @(posedge CLK) begin
    if (!CLR_N) begin
      presc_r  <= '0;
      deb_ce_r <= 1'b0;
    end else if (CE) begin
      if (presc_r == PRESC_LAST) begin
        presc_r  <= '0;
        deb_ce_r <= 1'b1;
      end else begin
        presc_r  <= presc_r + 1'b1;
        deb_ce_r <= 1'b0;
      end
    end else begin
      deb_ce_r <= 1'b0;
    end
  end

  // Next-state and setpoint logic; key priority START > MODE > INC > DEC.
  always_comb begin
    state_s   = state_r;
    set_min_s = set_min_r;
    set_sec_s = set_sec_r;
    load_s    = 1'b0;
    case (state_r)
      ST_IDLE, ST_SET_MIN, ST_SET_SEC: begin
        if (KEY_START) begin
          if (nonzero_s) begin
            state_s = ST_RUN;
            load_s  = 1'b1;
          end else begin
            state_s = ST_IDLE;
          end
        end else if (KEY_MODE) begin
          if (state_r == ST_IDLE)         state_s = ST_SET_MIN;
          else if (state_r == ST_SET_MIN) state_s = ST_SET_SEC;
          else                            state_s = ST_IDLE;
        end else if (KEY_INC) begin
          if (state_r == ST_SET_MIN) begin
            set_min_s = (set_min_r == MIN_LAST) ? 6'd0 : set_min_r + 6'd1;
          end else if (state_r == ST_SET_SEC) begin
            set_sec_s = (set_sec_r == SEC_LAST) ? 6'd0 : set_sec_r + 6'd1;
          end else begin
            set_min_s = set_min_r;
          end
        end else if (KEY_DEC) begin
          if (state_r == ST_SET_MIN) begin
            set_min_s = (set_min_r == 6'd0) ? MIN_LAST : set_min_r - 6'd1;
          end else if (state_r == ST_SET_SEC) begin
            set_sec_s = (set_sec_r == 6'd0) ? SEC_LAST : set_sec_r - 6'd1;
          end else begin
            set_min_s = set_min_r;
          end
        end else begin
          state_s = state_r;
        end
      end
      ST_RUN: begin
        if (TIMER_ZERO)     state_s = ST_DONE;
        else if (KEY_START) state_s = ST_PAUSE;
        else                state_s = ST_RUN;
      end
      ST_PAUSE: begin
        if (KEY_START)     state_s = ST_RUN;
        else if (KEY_MODE) state_s = ST_IDLE;
        else               state_s = ST_PAUSE;
      end
      ST_DONE: begin
        if (any_key_s) state_s = ST_IDLE;
        else           state_s = ST_DONE;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register with outputs decoded from the next state so they are registered.
  always_ff @(posedge CLK) begin
    if (!CLR_N) begin
      state_r   <= ST_IDLE;
      set_min_r <= 6'd0;
      set_sec_r <= 6'd0;
      load_r    <= 1'b0;
      run_r     <= 1'b0;
      alarm_r   <= 1'b0;
      rep_en_r  <= 1'b0;
    end else begin
      state_r   <= state_s;
      set_min_r <= set_min_s;
      set_sec_r <= set_sec_s;
      load_r    <= load_s;
      run_r     <= (state_s == ST_RUN);
      alarm_r   <= (state_s == ST_DONE);
      rep_en_r  <= (state_s == ST_SET_MIN) || (state_s == ST_SET_SEC);
    end
  end

  assign DEB_CE     = deb_ce_r;
  assign DEB_REP_EN = rep_en_r;
  assign SET_MIN    = set_min_r;
  assign SET_SEC    = set_sec_r;
  assign LOAD       = load_r;
  assign RUN        = run_r;
  assign ALARM      = alarm_r;
  assign STATE      = state_r;

endmodule

// File: tb/tb_timer_key_ctrl.sv
// Scoreboard bench for timer_key_ctrl: a reference model pushes expected
// outputs per driven cycle; they are popped and compared after the edge.
module tb_timer_key_ctrl;

  logic       CLK, CLR_N, CE;
  logic       KEY_MODE, KEY_INC, KEY_DEC, KEY_START, TIMER_ZERO;
  logic       DEB_CE, DEB_REP_EN, LOAD, RUN, ALARM;
  logic [5:0] SET_MIN, SET_SEC;
  logic [2:0] STATE;

  timer_key_ctrl #(
    .DEB_PRESC_BITS(3),
    .DEB_PRESC_MODULO(4),
    .MAX_MIN(59)
  ) dut (
    .CLK(CLK), .CLR_N(CLR_N), .CE(CE),
    .KEY_MODE(KEY_MODE), .KEY_INC(KEY_INC), .KEY_DEC(KEY_DEC),
    .KEY_START(KEY_START), .TIMER_ZERO(TIMER_ZERO),
    .DEB_CE(DEB_CE), .DEB_REP_EN(DEB_REP_EN),
    .SET_MIN(SET_MIN), .SET_SEC(SET_SEC),
    .LOAD(LOAD), .RUN(RUN), .ALARM(ALARM), .STATE(STATE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [2:0] st;
    logic [5:0] mn;
    logic [5:0] sc;
    logic       ld, rn, al, rep, dce;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   n_dce   = 0;

  // reference model state
  int m_st = 0, m_min = 0, m_sec = 0, m_ticks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  task automatic model_step(input logic rst_n, ce, km, ki, kd, ks, tz, output exp_t e);
    int key;
    logic ld, dce;
    ld  = 1'b0;
    dce = 1'b0;
    if (!rst_n) begin
      m_st = 0; m_min = 0; m_sec = 0; m_ticks = 0;
    end else begin
      if (ce) begin
        m_ticks = (m_ticks + 1) % 4;
        dce = (m_ticks == 0);
      end
      key = ks ? 1 : km ? 2 : ki ? 3 : kd ? 4 : 0;
      case (m_st)
        0, 1, 2: begin
          if (key == 1) begin
            if (m_min != 0 || m_sec != 0) begin m_st = 3; ld = 1'b1; end
            else m_st = 0;
          end else if (key == 2) m_st = (m_st == 2) ? 0 : m_st + 1;
          else if (key == 3 && m_st == 1) m_min = (m_min + 1) % 60;
          else if (key == 3 && m_st == 2) m_sec = (m_sec + 1) % 60;
          else if (key == 4 && m_st == 1) m_min = (m_min + 59) % 60;
          else if (key == 4 && m_st == 2) m_sec = (m_sec + 59) % 60;
        end
        3: if (tz) m_st = 5; else if (key == 1) m_st = 4;
        4: if (key == 1) m_st = 3; else if (key == 2) m_st = 0;
        5: if (key != 0) m_st = 0;
        default: m_st = 0;
      endcase
    end
    e.st  = 3'(m_st);
    e.mn  = 6'(m_min);
    e.sc  = 6'(m_sec);
    e.ld  = ld;
    e.rn  = (m_st == 3);
    e.al  = (m_st == 5);
    e.rep = (m_st == 1 || m_st == 2);
    e.dce = dce;
  endtask

  // drive one cycle, predict, then compare after the edge
  task automatic cycle(input logic rst_n, km, ki, kd, ks, tz);
    exp_t e;
    logic ce;
    ce = (cyc % 3 == 0);
    CLR_N = rst_n; CE = ce;
    KEY_MODE = km; KEY_INC = ki; KEY_DEC = kd; KEY_START = ks; TIMER_ZERO = tz;
    model_step(rst_n, ce, km, ki, kd, ks, tz, e);
    exp_q.push_back(e);
    @(posedge CLK);
    #1;
    cyc++;
    if (DEB_CE) n_dce++;
    if (exp_q.size() == 0) begin
      chk("queue_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk("STATE", 32'(STATE), 32'(e.st));
      chk("SET_MIN", 32'(SET_MIN), 32'(e.mn));
      chk("SET_SEC", 32'(SET_SEC), 32'(e.sc));
      chk("LOAD", 32'(LOAD), 32'(e.ld));
      chk("RUN", 32'(RUN), 32'(e.rn));
      chk("ALARM", 32'(ALARM), 32'(e.al));
      chk("DEB_REP_EN", 32'(DEB_REP_EN), 32'(e.rep));
      chk("DEB_CE", 32'(DEB_CE), 32'(e.dce));
    end
    KEY_MODE = 1'b0; KEY_INC = 1'b0; KEY_DEC = 1'b0; KEY_START = 1'b0; TIMER_ZERO = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic mode();  cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); endtask
  task automatic inc();   cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); endtask
  task automatic dec();   cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); endtask
  task automatic start(); cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); endtask
  task automatic reset(); cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); endtask

  initial begin
    CLR_N = 1'b0; CE = 1'b0;
    KEY_MODE = 1'b0; KEY_INC = 1'b0; KEY_DEC = 1'b0; KEY_START = 1'b0; TIMER_ZERO = 1'b0;
    @(negedge CLK);
    reset(); reset();
    chk("rst_state", 32'(STATE), 32'd0);
    chk("rst_outs", {27'd0, LOAD, RUN, ALARM, DEB_CE, DEB_REP_EN}, 32'd0);

    // prescaler: modulo 4, CE every 3rd clock -> one strobe per 12 clocks
    cyc = 0; n_dce = 0;
    idle(9);
    chk("dce_before_4th_tick", 32'(n_dce), 32'd0);
    idle(1);
    chk("dce_after_4th_tick", 32'(DEB_CE), 32'd1);
    idle(14);
    chk("dce_count_24", 32'(n_dce), 32'd2);

    // setpoint wrap: DEC from 0 -> 59, INC x61 in seconds -> 1
    mode(); dec();
    chk("min_wrap_59", 32'(SET_MIN), 32'd59);
    mode();
    for (int i = 0; i < 61; i++) inc();
    chk("sec_inc61", 32'(SET_SEC), 32'd1);
    dec(); dec();
    chk("sec_dec_wrap", 32'(SET_SEC), 32'd59);
    inc(); inc();
    mode();
    chk("rep_idle", 32'(DEB_REP_EN), 32'd0);

    // run/pause/resume with 00:05
    reset();
    mode(); mode();
    for (int i = 0; i < 5; i++) inc();
    mode();
    start();
    chk("load_on_start", 32'(LOAD), 32'd1);
    idle(2);
    start();
    chk("pause_state", 32'(STATE), 32'd4);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    start();
    chk("resume_noload", 32'(LOAD), 32'd0);

    // TIMER_ZERO beats START; any key leaves DONE without effect
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("done_alarm", 32'(ALARM), 32'd1);
    idle(2);
    inc();
    chk("done_exit_min", 32'(SET_MIN), 32'd0);
    chk("done_exit_sec", 32'(SET_SEC), 32'd5);

    // pause abort keeps setpoint
    start(); start(); mode();
    chk("abort_idle", 32'(STATE), 32'd0);

    // zero setpoint START handling
    reset();
    start();
    chk("zero_start_ignored", 32'(STATE), 32'd0);
    mode();
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("zero_start_setmin", 32'(STATE), 32'd0);

    // reset mid-RUN at 02:30
    mode(); inc(); inc(); mode();
    for (int i = 0; i < 30; i++) inc();
    mode(); start(); idle(2);
    chk("run_before_rst", 32'(RUN), 32'd1);
    reset();
    chk("rst_run", {24'd0, STATE, LOAD, RUN, ALARM, DEB_CE, DEB_REP_EN}, 32'd0);
    chk("rst_setpoint", {20'd0, SET_MIN, SET_SEC}, 32'd0);
    idle(6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
